control_filtro_pb5000: RTL

- Control unit (FSM plus sample-rate divider) that drives the filtropb5000 datapath.
- Each sample, it sequences one multiply-accumulate per clock through the datapath's single arithmetic unit, using register enables en1..en7 and mux selects selmuxS/selmuxC/selmuxZ.
- The arithmetic unit computes resultado = dato1 + dato2*dato3 (muxS = addend, muxC = coefficient, muxZ = multiplicand).
- Together with the datapath it forms the complete second-order low-pass section.

---
 rtl/control_filtro_pb5000_pkg.sv | 61 ++++++
 rtl/control_filtro_pb5000_divisor_muestreo.sv | 31 +++
 rtl/control_filtro_pb5000.sv | 100 ++++++++++
 3 files changed

// File: rtl/control_filtro_pb5000_pkg.sv
// Shared constants for the filtropb5000 controllers: FSM states, mux select codes,
// the packed control word and its per-state decode.
package control_filtro_pb5000_pkg;

    localparam int unsigned EN_W    = 7;
    localparam int unsigned SEL_S_W = 3;
    localparam int unsigned SEL_C_W = 2;
    localparam int unsigned SEL_Z_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_S5   = 3'd5,
        ST_S6   = 3'd6
    } state_t;

    localparam logic [SEL_S_W-1:0] SEL_S_ZERO  = 3'd0;
    localparam logic [SEL_S_W-1:0] SEL_S_UK    = 3'd1;
    localparam logic [SEL_S_W-1:0] SEL_S_ACUM1 = 3'd2;
    localparam logic [SEL_S_W-1:0] SEL_S_ACUM2 = 3'd3;
    localparam logic [SEL_S_W-1:0] SEL_S_ACUM3 = 3'd4;

    localparam logic [SEL_C_W-1:0] SEL_C_A1 = 2'd0;
    localparam logic [SEL_C_W-1:0] SEL_C_A2 = 2'd1;
    localparam logic [SEL_C_W-1:0] SEL_C_B0 = 2'd2;
    localparam logic [SEL_C_W-1:0] SEL_C_B1 = 2'd3;

    localparam logic [SEL_Z_W-1:0] SEL_Z_FK  = 3'd0;
    localparam logic [SEL_Z_W-1:0] SEL_Z_FK1 = 3'd1;
    localparam logic [SEL_Z_W-1:0] SEL_Z_FK2 = 3'd2;

    typedef struct packed {
        logic [EN_W:1]      en;
        logic [SEL_S_W-1:0] sel_s;
        logic [SEL_C_W-1:0] sel_c;
        logic [SEL_Z_W-1:0] sel_z;
        logic               busy;
        logic               yk_valid;
    } ctrl_t;

    // One MAC per state: resultado = muxS + muxC * muxZ, written to the enabled register.
    function automatic ctrl_t decode_state(input state_t st);
        ctrl_t c;
        c      = '0;
        c.busy = (st != ST_IDLE);
        case (st)
            ST_S1: begin c.sel_s = SEL_S_UK;    c.sel_c = SEL_C_A1; c.sel_z = SEL_Z_FK1; c.en[5] = 1'b1; end
            ST_S2: begin c.sel_s = SEL_S_ACUM1; c.sel_c = SEL_C_A2; c.sel_z = SEL_Z_FK2; c.en[2] = 1'b1; end
            ST_S3: begin c.sel_s = SEL_S_ZERO;  c.sel_c = SEL_C_B0; c.sel_z = SEL_Z_FK;  c.en[6] = 1'b1; end
            ST_S4: begin c.sel_s = SEL_S_ACUM2; c.sel_c = SEL_C_B1; c.sel_z = SEL_Z_FK1; c.en[7] = 1'b1; end
            ST_S5: begin c.sel_s = SEL_S_ACUM3; c.sel_c = SEL_C_B0; c.sel_z = SEL_Z_FK2; c.en[1] = 1'b1; end
            ST_S6: begin c.en[3] = 1'b1; c.en[4] = 1'b1; c.yk_valid = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_filtro_pb5000_divisor_muestreo.sv
// Sample-rate divider: free-running counter gated by run, one-cycle tick every SAMPLE_DIV clocks.
module control_filtro_pb5000_divisor_muestreo #(
    parameter int unsigned SAMPLE_DIV = 2000,
    parameter int unsigned DIV_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick_c
);

    if (SAMPLE_DIV < 8 || (64'd1 << DIV_W) < 64'(SAMPLE_DIV)) begin : g_cfg_err
        $error("divisor_muestreo: SAMPLE_DIV must be >= 8 and representable in DIV_W bits");
    end

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick_c = run && (cnt == CNT_LAST);

    // Dropping run restarts the sample period from zero.
    always_ff @(posedge clk) begin
        if (reset || !run || tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/control_filtro_pb5000.sv
// Controller for the filtropb5000 datapath: six-step MAC sequence per sample tick.
// Build option FILTRO_EXT_TICK_EN replaces the divider with ext_tick and adds a sticky overrun flag.
module control_filtro_pb5000
    import control_filtro_pb5000_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 2000,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
`ifdef FILTRO_EXT_TICK_EN
    input  logic                ext_tick,
    output logic                overrun,
`endif
    output logic                en1,
    output logic                en2,
    output logic                en3,
    output logic                en4,
    output logic                en5,
    output logic                en6,
    output logic                en7,
    output logic [SEL_S_W-1:0]  selmuxS,
    output logic [SEL_C_W-1:0]  selmuxC,
    output logic [SEL_Z_W-1:0]  selmuxZ,
    output logic                busy,
    output logic                yk_valid
);

    state_t state, state_next;
    ctrl_t  ctrl_q, ctrl_next;
    logic   tick_c;

`ifdef FILTRO_EXT_TICK_EN
    logic overrun_q, overrun_next;

    assign tick_c  = run & ext_tick;
    assign overrun = overrun_q;
`else
    control_filtro_pb5000_divisor_muestreo #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .DIV_W      (DIV_W)
    ) u_divisor (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .tick_c (tick_c)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            ctrl_q <= '0;
`ifdef FILTRO_EXT_TICK_EN
            overrun_q <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            ctrl_q <= ctrl_next;
`ifdef FILTRO_EXT_TICK_EN
            overrun_q <= overrun_next;
`endif
        end
    end

    // Outputs are the decode of the next state, registered so they line up with state.
    always_comb begin
        state_next = state;
        ctrl_next  = '0;
`ifdef FILTRO_EXT_TICK_EN
        overrun_next = overrun_q | (tick_c & (state != ST_IDLE));
`endif
        case (state)
            ST_IDLE: if (tick_c) state_next = ST_S1;
            ST_S1:   state_next = ST_S2;
            ST_S2:   state_next = ST_S3;
            ST_S3:   state_next = ST_S4;
            ST_S4:   state_next = ST_S5;
            ST_S5:   state_next = ST_S6;
            ST_S6:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        ctrl_next = decode_state(state_next);
    end

    assign en1      = ctrl_q.en[1];
    assign en2      = ctrl_q.en[2];
    assign en3      = ctrl_q.en[3];
    assign en4      = ctrl_q.en[4];
    assign en5      = ctrl_q.en[5];
    assign en6      = ctrl_q.en[6];
    assign en7      = ctrl_q.en[7];
    assign selmuxS  = ctrl_q.sel_s;
    assign selmuxC  = ctrl_q.sel_c;
    assign selmuxZ  = ctrl_q.sel_z;
    assign busy     = ctrl_q.busy;
    assign yk_valid = ctrl_q.yk_valid;

endmodule
